// File: rtl/mem_resp_sram.sv
// SRAM-backed responder for the memory request/response protocol. It services one request per
// cycle and returns in-order responses after a fixed latency. Optional build macro:
// MEM_RESP_SRAM_RAND_STALL_EN adds about 25% pseudo-random request back-pressure.
`timescale 1ns/1ps

module mem_resp_sram #(
  parameter int p_opaq_bits = 8,
  parameter int p_num_words = 1024,
  parameter int p_latency   = 2,
  parameter int p_max_outst = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_op,
  input  logic [p_opaq_bits-1:0] req_opaque,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_data,
  input  logic [3:0]             req_strb,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic                   resp_op,
  output logic [p_opaq_bits-1:0] resp_opaque,
  output logic [31:0]            resp_data
);

  localparam int AW = $clog2(p_num_words);
  localparam int CW = $clog2(p_max_outst + 1);
  localparam int PW = (p_max_outst > 1) ? $clog2(p_max_outst) : 1;

  typedef struct packed {
    logic                   op;
    logic [p_opaq_bits-1:0] opaque;
    logic [31:0]            data;
  } resp_t;

  typedef struct packed {
    logic  valid;
    resp_t r;
  } stage_t;

  logic [31:0]   mem [p_num_words];
  logic [CW-1:0] outst_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  resp_t         fifo_q [p_max_outst];
  resp_t         head;
  stage_t        acc_e, push_e;
  logic [AW-1:0] idx;
  logic          req_fire, resp_fire, stall, push, pop;
  logic          unused_addr_bits;

  assign idx              = req_addr[2 +: AW];
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef MEM_RESP_SRAM_RAND_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign req_rdy   = (outst_cnt < CW'(p_max_outst)) && !stall;
  assign req_fire  = req_val && req_rdy;
  assign resp_fire = resp_val && resp_rdy;

  // A response leaving this cycle does not free its slot until the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_cnt <= '0;
    end else begin
      case ({req_fire, resp_fire})
        2'b10:   outst_cnt <= outst_cnt + CW'(1);
        2'b01:   outst_cnt <= outst_cnt - CW'(1);
        default: outst_cnt <= outst_cnt;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (req_fire && req_op) begin
      for (int b = 0; b < 4; b++) begin
        if (req_strb[b]) mem[idx][8*b +: 8] <= req_data[8*b +: 8];
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    acc_e          = '0;
    acc_e.valid    = req_fire;
    acc_e.r.op     = req_op;
    acc_e.r.opaque = req_opaque;
    acc_e.r.data   = req_op ? 32'h0 : mem[idx];
  end

  // The accept edge and the FIFO push edge together account for two cycles of latency.
  generate
    if (p_latency == 1) begin : g_direct
      assign push_e = acc_e;
    end else begin : g_line
      stage_t line_q [p_latency-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < p_latency - 1; i++) line_q[i] <= '0;
        end else begin
          line_q[0] <= acc_e;
          for (int i = 1; i < p_latency - 1; i++) line_q[i] <= line_q[i-1];
        end
      end
      assign push_e = line_q[p_latency-2];
    end
  endgenerate

  assign push = push_e.valid;
  assign pop  = resp_fire;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(p_max_outst - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments, so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= push_e.r;
  end

  // The outstanding count bounds the entries in the line and FIFO, so a push into a full FIFO
  // can only come from a broken invariant.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && fifo_cnt == CW'(p_max_outst)));

  assign head        = fifo_q[rd_ptr];
  assign resp_val    = (fifo_cnt != '0);
  assign resp_op     = resp_val && head.op;
  assign resp_opaque = resp_val ? head.opaque : '0;
  assign resp_data   = resp_val ? head.data : 32'h0;

endmodule

// File: tb/tb_mem_resp_sram.sv
// Self-checking bench for mem_resp_sram. It pairs a transaction-level model (model memory plus a
// queue of expected responses with earliest-visible cycle) with directed scenarios.
`timescale 1ns/1ps

module tb_mem_resp_sram;
  localparam int OB  = 8;
  localparam int NW  = 1024;
  localparam int LAT = 2;
  localparam int MO  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_val, req_rdy, req_op;
  logic [OB-1:0] req_opaque;
  logic [31:0]   req_addr, req_data;
  logic [3:0]    req_strb;
  logic          resp_val, resp_rdy, resp_op;
  logic [OB-1:0] resp_opaque;
  logic [31:0]   resp_data;

  always #5 clk = ~clk;

  mem_resp_sram #(
    .p_opaq_bits(OB), .p_num_words(NW), .p_latency(LAT), .p_max_outst(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_opaque(req_opaque),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_op(resp_op),
    .resp_opaque(resp_opaque), .resp_data(resp_data)
  );

  typedef struct {
    logic          op;
    logic [OB-1:0] opaque;
    logic [31:0]   data;
    int            ready;
  } exp_t;

  typedef struct {
    logic          op;
    logic [OB-1:0] opaque;
    logic [31:0]   data;
  } log_t;

  exp_t        exp_q[$];
  log_t        resp_log[$];
  logic [31:0] model_mem [NW];
  int          ecnt = 0;
  int          n_acc = 0;
  int          last_fire = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Model update on every rising edge, using the pre-edge handshake values.
  initial begin : model
    forever begin
      @(posedge clk);
      ecnt++;
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        if (resp_val && resp_rdy) begin
          resp_log.push_back('{resp_op, resp_opaque, resp_data});
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (req_val && req_rdy) begin
          exp_t e;
          int   w;
          w        = int'(req_addr[11:2]);
          e.op     = req_op;
          e.opaque = req_opaque;
          e.ready  = ecnt + LAT - 1;
          if (req_op) begin
            for (int b = 0; b < 4; b++)
              if (req_strb[b]) model_mem[w][8*b +: 8] = req_data[8*b +: 8];
            e.data = 32'h0;
          end else begin
            e.data = model_mem[w];
          end
          exp_q.push_back(e);
          n_acc++;
          last_fire = ecnt;
        end
      end
    end
  end

  // Compare process: check the DUT outputs against the model mid-cycle.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic exp_v;
        check("req_rdy", req_rdy, exp_q.size() < MO);
        exp_v = 1'b0;
        if (exp_q.size() > 0) exp_v = (ecnt >= exp_q[0].ready);
        check("resp_val", resp_val, exp_v);
        if (exp_v) begin
          check("resp_op", resp_op, exp_q[0].op);
          check("resp_opaque", resp_opaque, exp_q[0].opaque);
          check("resp_data", resp_data, exp_q[0].data);
        end
      end
    end
  end

  // Called at posedge+1. Holds the request until it fires and returns at posedge+1.
  task automatic send(input logic op, input logic [OB-1:0] tag, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
    int   n;
    logic done;
    n          = 0;
    done       = 1'b0;
    req_op     = op;
    req_opaque = tag;
    req_addr   = addr;
    req_data   = data;
    req_strb   = strb;
    req_val    = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      if (req_rdy) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) check("send_timeout", 32'(done), 32'h1);
    req_val = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || resp_val) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_resp_val", resp_val, 1'b0);
  endtask

  task automatic check_log(input string name, input int i, input logic op,
                           input logic [OB-1:0] tag, input logic [31:0] data);
    check({name, "_present"}, 32'(resp_log.size() > i), 32'h1);
    if (resp_log.size() > i) begin
      check({name, "_op"}, resp_log[i].op, op);
      check({name, "_tag"}, resp_log[i].opaque, tag);
      check({name, "_data"}, resp_log[i].data, data);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int base, f0;
    rst_n = 1'b0; req_val = 1'b0; req_op = 1'b0; req_opaque = '0;
    req_addr = '0; req_data = '0; req_strb = '0; resp_rdy = 1'b1;

    @(posedge clk); #1;
    check("rst_resp_val_in_reset", resp_val, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_rdy", req_rdy, 1'b1);
    check("rst_resp_op", resp_op, 1'b0);
    check("rst_resp_opaque", resp_opaque, 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    @(posedge clk); #1;

    // Full write then read of the same word.
    resp_log.delete();
    send(1'b1, 8'd3, 32'h10, 32'hDEADBEEF, 4'hF);
    send(1'b0, 8'd4, 32'h10, 32'h0, 4'h0);
    drain();
    check("t1_count", resp_log.size(), 2);
    check_log("t1_wr", 0, 1'b1, 8'd3, 32'h0);
    check_log("t1_rd", 1, 1'b0, 8'd4, 32'hDEADBEEF);

    // Partial byte strobes.
    resp_log.delete();
    send(1'b1, 8'd5, 32'h20, 32'hFFFFFFFF, 4'hF);
    send(1'b1, 8'd6, 32'h20, 32'h11223344, 4'b0101);
    send(1'b0, 8'd7, 32'h20, 32'h0, 4'h0);
    drain();
    check_log("t2_wr", 1, 1'b1, 8'd6, 32'h0);
    check_log("t2_rd", 2, 1'b0, 8'd7, 32'hFF22FF44);

    // A zero-strobe write still responds and leaves the word alone; then exact read latency.
    resp_log.delete();
    send(1'b1, 8'd30, 32'h10, 32'h12345678, 4'h0);
    drain();
    req_op = 1'b0; req_opaque = 8'd31; req_addr = 32'h10; req_val = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    @(negedge clk); check("lat_cycle1", resp_val, 1'b0);
    @(negedge clk); check("lat_cycle2", resp_val, 1'b1);
    @(negedge clk); check("lat_cycle3", resp_val, 1'b0);
    @(posedge clk); #1;
    check_log("t3_wr0", 0, 1'b1, 8'd30, 32'h0);
    check_log("t3_rd", 1, 1'b0, 8'd31, 32'hDEADBEEF);

    // Back-pressure: six reads against a four-deep window.
    resp_log.delete();
    base = n_acc;
    resp_rdy = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'b0, 8'(10 + i), 32'h20, 32'h0, 4'h0);
      end
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_accepted", n_acc - base, 4);
        check("bp_req_rdy", req_rdy, 1'b0);
        @(posedge clk); #1;
        resp_rdy = 1'b1;
      end
    join
    drain();
    check("bp_count", resp_log.size(), 6);
    for (int i = 0; i < 6; i++) check_log("bp_order", i, 1'b0, 8'(10 + i), 32'hFF22FF44);

    // Back-to-back throughput.
    send(1'b0, 8'd40, 32'h20, 32'h0, 4'h0);
    f0 = last_fire;
    for (int i = 1; i < 8; i++) send(1'b0, 8'(40 + i), 32'h20, 32'h0, 4'h0);
    check("tput_span", last_fire - f0, 7);
    drain();

    // Address aliasing and ignored low address bits.
    resp_log.delete();
    send(1'b1, 8'd20, 32'h1000, 32'h0000005A, 4'hF);
    send(1'b0, 8'd21, 32'h0, 32'h0, 4'h0);
    send(1'b0, 8'd22, 32'h13, 32'h0, 4'h0);
    drain();
    check_log("alias_rd", 1, 1'b0, 8'd21, 32'h0000005A);
    check_log("lowbits_rd", 2, 1'b0, 8'd22, 32'hDEADBEEF);

    // Reset with three requests in flight.
    resp_rdy = 1'b0;
    send(1'b0, 8'd50, 32'h20, 32'h0, 4'h0);
    send(1'b0, 8'd51, 32'h20, 32'h0, 4'h0);
    send(1'b0, 8'd52, 32'h20, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_resp_val", resp_val, 1'b0);
    resp_log.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    resp_rdy = 1'b1;
    @(negedge clk);
    check("rst_mid_req_rdy", req_rdy, 1'b1);
    repeat (10) @(posedge clk);
    #1 check("rst_no_stale", resp_log.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
